grahzm8_ram_arbiter: RTL and testbench
======================================

Name: grahzm8_ram_arbiter

Overview:
- Shares the single 256x8 data RAM between the Grah-8 core (CPU port) and a loader/debug DMA port.
- Drives the RAM load/save/address/data pins and allows at most one access per cycle.
- Arbitration uses an owner state machine with round-robin tie-break and a burst cap.
- Returns read data registered with a one-cycle valid pulse.

Parameters:
- MAX_BURST, 4: max consecutive granted beats for one owner while the other side is requesting; range 1..15.
- CPU_PRIORITY, 0: 1 = CPU wins simultaneous requests from IDLE; 0 = round-robin.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  8  CPU RAM address
- cpu_wdata  in  8  CPU write data
- cpu_gnt  out  1  access issued this cycle
- cpu_rdata  out  8  captured read data
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated
- dma_req, dma_we, dma_addr[8], dma_wdata[8]  in  same meaning for the DMA port
- dma_last  in  1  marks final beat of a DMA burst
- dma_gnt  out  1; dma_rdata  out  8; dma_rvalid  out  1  as for CPU
- ram_load  out  1  RAM read enable
- ram_save  out  1  RAM write enable, committed at clk edge
- ram_addr  out  8; ram_wdata  out  8  RAM address / write data
- ram_rdata  in  8  RAM read data, combinational from ram_addr while ram_load=1
- stat_cpu_beats  out  16; stat_dma_beats  out  16  statistics (see Optional Feature)

Behaviour:
- State owner ∈ {IDLE, OWN_CPU, OWN_DMA}.
- Grant and RAM drive:
  - cpu_gnt = cpu_req & (owner==OWN_CPU); dma_gnt = dma_req & (owner==OWN_DMA). Combinational, never both 1.
  - ram_addr/ram_wdata are muxed from the granted port; 0 when none.
  - ram_load = gnt & ~we; ram_save = gnt & we.
- IDLE: no grants. At the edge:
  - only one req → that owner;
  - both → CPU if CPU_PRIORITY=1, else the side opposite rr_last;
  - none → stay.
  - Arbitration latency from IDLE: 1 cycle.
- OWN_x: one beat per cycle while req_x=1. burst_cnt (4 bits) increments per granted beat and clears on every owner change.
- Handover at the edge, OWN_x:
  - req_x=0 → other owner if other req, else IDLE.
  - OWN_CPU: cpu_gnt & dma_req & burst_cnt==MAX_BURST-1 → OWN_DMA directly, with no idle cycle.
  - OWN_DMA: dma_gnt & dma_last → OWN_CPU if cpu_req, else IDLE.
  - OWN_DMA: dma_gnt & cpu_req & burst_cnt==MAX_BURST-1 → OWN_CPU.
- rr_last is updated to the owner being left on every exit from OWN_x.
- Read path: on an edge with a granted read, x_rdata <= ram_rdata and x_rvalid=1 for the next cycle only. x_rdata holds until the next read. Write beats produce no rvalid.
- Boundary cases:
  - Request dropped in the same cycle → gnt=0, no RAM access.
  - Address 0xFF is passed through unchanged; no arithmetic is applied.
  - Back-to-back reads give rvalid high on consecutive cycles.
- Reset (rst=0, async): owner=IDLE, burst_cnt=0, rr_last=DMA (CPU served first), all rdata=0, all rvalid=0.
  - Grants and ram_load/ram_save drop immediately, so an in-progress write is not committed.
  - A burst interrupted by reset is not resumed.

Optional Feature:
- Macro GRAHZM8_ARB_STATS_EN.
- Defined: stat_cpu_beats/stat_dma_beats count granted beats (reads + writes). They saturate at 0xFFFF and clear on reset.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package grahzm8_arb_pkg holds:
  - owner_e enum (IDLE, OWN_CPU, OWN_DMA);
  - ADDR_W=8, DATA_W=8, BURST_W=4, STAT_W=16.
- One sub-module, grahzm8_arb_fsm: owner, burst_cnt, rr_last and next-state logic; outputs owner.
- Top level holds the grant/mux logic, read capture and stats.

Test Plan:
- Reset, then cpu_req read addr 0x10 with RAM[0x10]=0x5A:
  - cycle 1: cpu_gnt=0;
  - cycle 2: cpu_gnt=1, ram_load=1, ram_addr=0x10;
  - cycle 3: cpu_rvalid=1, cpu_rdata=0x5A.
- Both request together after reset, CPU_PRIORITY=0: CPU granted first. Next simultaneous arbitration from IDLE grants DMA.
- CPU holds req for 10 writes, DMA requesting, MAX_BURST=4: CPU gets 4 beats, then DMA is granted on the next cycle with no idle gap.
- DMA burst writes 0xFE,0xFF with dma_last on 0xFF, cpu_req waiting: owner becomes OWN_CPU on the edge after the last beat. RAM[0xFE..0xFF] contain the written data.
- Assert rst low mid-write (dma_gnt=1, addr 0x20, data 0x33, RAM[0x20]=0x00): ram_save drops immediately; RAM[0x20] stays 0x00; owner=IDLE, rvalid=0.
- GRAHZM8_ARB_STATS_EN defined:
  - 3 CPU beats + 5 DMA beats → stat_cpu_beats=3, stat_dma_beats=5;
  - after 70000 CPU beats → stat_cpu_beats=0xFFFF.

Source files
------------

// File: rtl/grahzm8_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : grahzm8_arb_pkg
//  Purpose  : Shared widths, owner encoding and a saturating-increment helper
//             for the Grah-8 data RAM arbiter.
//  Contents : owner_e, ADDR_W, DATA_W, BURST_W, STAT_W, sat_inc()
//  Revision : 1.0 - initial release
// ============================================================================
package grahzm8_arb_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int BURST_W = 4;
  localparam int STAT_W  = 16;

  // Current owner of the RAM port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } owner_e;

  // Increment by one when en is set, sticking at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v,
                                                input logic              en);
    if (en && (v != {STAT_W{1'b1}})) begin
      return v + STAT_W'(1);
    end
    return v;
  endfunction

endpackage : grahzm8_arb_pkg
`default_nettype wire

// File: rtl/grahzm8_arb_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : grahzm8_arb_fsm
//  Purpose  : Owner state machine for the Grah-8 data RAM arbiter. Tracks the
//             current owner, the per-owner burst length and which side was
//             served last (for round-robin tie-break out of IDLE).
//  Ports    : clk, rst (async, active-low)
//             cpu_req, dma_req  - port requests
//             dma_last          - final beat of a DMA burst
//             owner             - current owner (drives the grant logic)
//  Revision : 1.0 - initial release
// ============================================================================
module grahzm8_arb_fsm
  import grahzm8_arb_pkg::*;
#(
  parameter int MAX_BURST    = 4,
  parameter int CPU_PRIORITY = 0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   dma_last,
  output owner_e owner
);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  owner_e             owner_q, owner_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               rr_last_dma_q, rr_last_dma_d;  // 1: DMA was left last

  logic cpu_beat;
  logic dma_beat;
  logic burst_done;

  always_comb begin
    owner_d       = owner_q;
    burst_cnt_d   = burst_cnt_q;
    rr_last_dma_d = rr_last_dma_q;

    cpu_beat   = cpu_req & (owner_q == OWN_CPU);
    dma_beat   = dma_req & (owner_q == OWN_DMA);
    // The beat being granted now is the MAX_BURST-th of this ownership.
    burst_done = (burst_cnt_q == BURST_LAST);

    case (owner_q)
      IDLE: begin
        if (cpu_req && dma_req) begin
          // rr_last_dma_q set means DMA was served last, so CPU goes next.
          owner_d = ((CPU_PRIORITY != 0) || rr_last_dma_q) ? OWN_CPU : OWN_DMA;
        end else if (cpu_req) begin
          owner_d = OWN_CPU;
        end else if (dma_req) begin
          owner_d = OWN_DMA;
        end
      end
      OWN_CPU: begin
        if (!cpu_req) begin
          owner_d = dma_req ? OWN_DMA : IDLE;
        end else if (dma_req && burst_done) begin
          owner_d = OWN_DMA;
        end
      end
      OWN_DMA: begin
        if (!dma_req || dma_last) begin
          owner_d = cpu_req ? OWN_CPU : IDLE;
        end else if (cpu_req && burst_done) begin
          owner_d = OWN_CPU;
        end
      end
      default: owner_d = IDLE;
    endcase

    if (owner_d != owner_q) begin
      burst_cnt_d = '0;
      if (owner_q != IDLE) begin
        rr_last_dma_d = (owner_q == OWN_DMA);
      end
    end else if ((cpu_beat || dma_beat) && !burst_done) begin
      // Sticks at the cap while uncontended, so a late request from the
      // other side waits at most one more beat instead of a counter wrap.
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q       <= IDLE;
      burst_cnt_q   <= '0;
      rr_last_dma_q <= 1'b1;
    end else begin
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      rr_last_dma_q <= rr_last_dma_d;
    end
  end

  assign owner = owner_q;

endmodule : grahzm8_arb_fsm
`default_nettype wire

// File: rtl/grahzm8_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : grahzm8_ram_arbiter
//  Purpose  : Shares the 256x8 Grah-8 data RAM between the CPU port and a
//             loader/debug DMA port. At most one access per cycle; read data
//             is registered and flagged with a one-cycle rvalid pulse.
//  Ports    : clk, rst (async, active-low)
//             cpu_req/we/addr/wdata -> cpu_gnt, cpu_rdata, cpu_rvalid
//             dma_req/we/addr/wdata/last -> dma_gnt, dma_rdata, dma_rvalid
//             ram_load, ram_save, ram_addr, ram_wdata -> RAM; ram_rdata <- RAM
//             stat_cpu_beats, stat_dma_beats - granted-beat counters
//  Options  : GRAHZM8_ARB_STATS_EN - enables the saturating beat counters;
//             without it the stat outputs are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module grahzm8_ram_arbiter
  import grahzm8_arb_pkg::*;
#(
  parameter int MAX_BURST    = 4,
  parameter int CPU_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  // CPU port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  // DMA port
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_last,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  // RAM pins
  output logic              ram_load,
  output logic              ram_save,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  // Statistics
  output logic [STAT_W-1:0] stat_cpu_beats,
  output logic [STAT_W-1:0] stat_dma_beats
);

  owner_e owner;

  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_rvalid_q, dma_rvalid_d;

  grahzm8_arb_fsm #(
    .MAX_BURST    (MAX_BURST),
    .CPU_PRIORITY (CPU_PRIORITY)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .dma_last (dma_last),
    .owner    (owner)
  );

  // Grants follow the registered owner, so an async reset removes them
  // (and the RAM strobes) immediately, before any write can commit.
  always_comb begin
    cpu_gnt   = cpu_req & (owner == OWN_CPU);
    dma_gnt   = dma_req & (owner == OWN_DMA);
    ram_addr  = '0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
    ram_load = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
    ram_save = (cpu_gnt &  cpu_we) | (dma_gnt &  dma_we);
  end

  // Read capture: data holds until the next read beat of the same port.
  always_comb begin
    cpu_rvalid_d = cpu_gnt & ~cpu_we;
    dma_rvalid_d = dma_gnt & ~dma_we;
    cpu_rdata_d  = cpu_rvalid_d ? ram_rdata : cpu_rdata_q;
    dma_rdata_d  = dma_rvalid_d ? ram_rdata : dma_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_rvalid = dma_rvalid_q;

`ifdef GRAHZM8_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cpu_q, stat_cpu_d;
  logic [STAT_W-1:0] stat_dma_q, stat_dma_d;

  always_comb begin
    stat_cpu_d = sat_inc(stat_cpu_q, cpu_gnt);
    stat_dma_d = sat_inc(stat_dma_q, dma_gnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cpu_q <= '0;
      stat_dma_q <= '0;
    end else begin
      stat_cpu_q <= stat_cpu_d;
      stat_dma_q <= stat_dma_d;
    end
  end

  assign stat_cpu_beats = stat_cpu_q;
  assign stat_dma_beats = stat_dma_q;
`else
  assign stat_cpu_beats = '0;
  assign stat_dma_beats = '0;
`endif

endmodule : grahzm8_ram_arbiter
`default_nettype wire

// File: tb/tb_grahzm8_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grahzm8_ram_arbiter
//  Purpose  : Self-checking bench for grahzm8_ram_arbiter. Read expectations
//             come from a shadow copy of RAM kept per issued write; a forked
//             monitor pops them when rvalid appears and also checks grant
//             legality, the RAM pin mux and the contended burst cap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grahzm8_ram_arbiter;
  import grahzm8_arb_pkg::*;

  localparam int MAX_BURST    = 4;
  localparam int CPU_PRIORITY = 0;
  localparam int WAIT_LIMIT   = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_last;
  logic [7:0]  cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        ram_load, ram_save;
  logic [7:0]  ram_addr, ram_wdata, ram_rdata;
  logic [15:0] stat_cpu_beats, stat_dma_beats;

  always #5 clk = ~clk;

  grahzm8_ram_arbiter #(
    .MAX_BURST    (MAX_BURST),
    .CPU_PRIORITY (CPU_PRIORITY)
  ) dut (
    .clk (clk), .rst (rst),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .cpu_gnt (cpu_gnt), .cpu_rdata (cpu_rdata), .cpu_rvalid (cpu_rvalid),
    .dma_req (dma_req), .dma_we (dma_we), .dma_addr (dma_addr), .dma_wdata (dma_wdata),
    .dma_last (dma_last), .dma_gnt (dma_gnt), .dma_rdata (dma_rdata), .dma_rvalid (dma_rvalid),
    .ram_load (ram_load), .ram_save (ram_save), .ram_addr (ram_addr),
    .ram_wdata (ram_wdata), .ram_rdata (ram_rdata),
    .stat_cpu_beats (stat_cpu_beats), .stat_dma_beats (stat_dma_beats)
  );

  // RAM behind the arbiter: combinational read, write on the clock edge.
  logic [7:0] mem [256];
  assign ram_rdata = ram_load ? mem[ram_addr] : 8'h00;
  always @(posedge clk) if (ram_save) mem[ram_addr] <= ram_wdata;

  typedef struct { logic [7:0] data; int cyc; } exp_t;
  exp_t       cpu_exp[$];
  exp_t       dma_exp[$];
  logic [7:0] shadow [256];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;

  // monitor-owned state
  exp_t        mon_e;
  int          cpu_streak, dma_streak;
  logic [17:0] exp_bus;
  logic        legal;

  logic [1:0]  t3_exp [10];
  logic [7:0]  t3_caddr, t3_daddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_last = 1'b0;
    repeat (2) @(posedge clk);
    cpu_exp.delete();
    dma_exp.delete();
    #1 rst = 1'b1;
  endtask

  // One CPU beat: request, wait (bounded) for the grant, record expectation.
  task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    int waited = 0;
    exp_t e;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (!cpu_gnt && waited < WAIT_LIMIT) begin
      waited++;
      @(negedge clk);
    end
    check("cpu_grant_in_time", {31'd0, cpu_gnt}, 32'd1);
    if (cpu_gnt) begin
      if (we) shadow[a] = d;
      else begin
        e.data = shadow[a]; e.cyc = cyc;
        cpu_exp.push_back(e);
      end
    end
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic dma_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic last);
    int waited = 0;
    exp_t e;
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d; dma_last = last;
    @(negedge clk);
    while (!dma_gnt && waited < WAIT_LIMIT) begin
      waited++;
      @(negedge clk);
    end
    check("dma_grant_in_time", {31'd0, dma_gnt}, 32'd1);
    if (dma_gnt) begin
      if (we) shadow[a] = d;
      else begin
        e.data = shadow[a]; e.cyc = cyc;
        dma_exp.push_back(e);
      end
    end
    tick();
    dma_req = 1'b0; dma_last = 1'b0;
  endtask

  initial begin
    cpu_streak = 0; dma_streak = 0;
    do_reset();

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      // Monitor / scoreboard
      forever begin
        @(negedge clk);
        if (rst) begin
          legal = !(cpu_gnt && dma_gnt) && (!cpu_gnt || cpu_req) && (!dma_gnt || dma_req);
          check("grant_legal", {31'd0, legal}, 32'd1);
          exp_bus = cpu_gnt ? {~cpu_we, cpu_we, cpu_addr, cpu_wdata} :
                    dma_gnt ? {~dma_we, dma_we, dma_addr, dma_wdata} : 18'd0;
          check("ram_bus", {14'd0, ram_load, ram_save, ram_addr, ram_wdata}, {14'd0, exp_bus});
          cpu_streak = !cpu_gnt ? 0 : (dma_req ? cpu_streak + 1 : cpu_streak);
          dma_streak = !dma_gnt ? 0 : (cpu_req ? dma_streak + 1 : dma_streak);
          if (cpu_gnt && dma_req) check("cpu_burst_cap", {31'd0, cpu_streak <= MAX_BURST}, 32'd1);
          if (dma_gnt && cpu_req) check("dma_burst_cap", {31'd0, dma_streak <= MAX_BURST}, 32'd1);
          if (cpu_exp.size() > 0 && cpu_exp[0].cyc < cyc - 1) begin
            mon_e = cpu_exp.pop_front();
            check("cpu_rvalid_missing", {31'd0, cpu_rvalid}, 32'd1);
          end else if (cpu_exp.size() > 0 && cpu_exp[0].cyc == cyc - 1) begin
            mon_e = cpu_exp.pop_front();
            check("cpu_read", {23'd0, cpu_rvalid, cpu_rdata}, {23'd1, mon_e.data});
          end else if (cpu_rvalid) begin
            check("cpu_rvalid_spurious", {31'd0, cpu_rvalid}, 32'd0);
          end
          if (dma_exp.size() > 0 && dma_exp[0].cyc < cyc - 1) begin
            mon_e = dma_exp.pop_front();
            check("dma_rvalid_missing", {31'd0, dma_rvalid}, 32'd1);
          end else if (dma_exp.size() > 0 && dma_exp[0].cyc == cyc - 1) begin
            mon_e = dma_exp.pop_front();
            check("dma_read", {23'd0, dma_rvalid, dma_rdata}, {23'd1, mon_e.data});
          end else if (dma_rvalid) begin
            check("dma_rvalid_spurious", {31'd0, dma_rvalid}, 32'd0);
          end
        end else begin
          cpu_streak = 0; dma_streak = 0;
        end
      end
    join_none

    // Fill RAM through the arbiter so shadow and RAM start identical.
    for (int i = 0; i < 128; i++) cpu_op(1'b1, 8'(i), 8'($urandom));
    for (int i = 128; i < 256; i++) dma_op(1'b1, 8'(i), 8'($urandom), 1'b0);
    cpu_op(1'b1, 8'h10, 8'h5A);
    cpu_op(1'b1, 8'h20, 8'h00);
    tick();

    // ---- Reset values, then single CPU read with its latency ----
    do_reset();
    check("reset_outputs", {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_load, ram_save},
          32'd0);
    check("reset_rdata", {16'd0, cpu_rdata, dma_rdata}, 32'd0);
    check("reset_stats", {stat_cpu_beats, stat_dma_beats}, 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(negedge clk);
    check("t1_cycle1_gnt", {31'd0, cpu_gnt}, 32'd0);
    @(negedge clk);
    check("t1_cycle2_access", {22'd0, cpu_gnt, ram_load, ram_addr}, {22'd0, 2'b11, 8'h10});
    mon_e.data = 8'h5A; mon_e.cyc = cyc;
    cpu_exp.push_back(mon_e);
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    check("t1_cycle3_rdata", {23'd0, cpu_rvalid, cpu_rdata}, {23'd1, 8'h5A});
    tick();

    // ---- Round-robin out of IDLE ----
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h02; cpu_wdata = 8'hC2;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h82; dma_wdata = 8'hD2;
    @(negedge clk);
    check("t2_idle_first", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
    @(negedge clk);
    check("t2_cpu_first", {30'd0, cpu_gnt, dma_gnt}, 32'd2);
    shadow[8'h02] = 8'hC2;
    tick();
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
    check("t2_dropped_req", {30'd0, cpu_gnt, dma_gnt, ram_save}, 32'd0);
    tick();
    cpu_wdata = 8'hC3; dma_wdata = 8'hD3; cpu_addr = 8'h03; dma_addr = 8'h83;
    cpu_req = 1'b1; dma_req = 1'b1;
    @(negedge clk);
    check("t2_idle_second", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
    @(negedge clk);
    check("t2_dma_second", {30'd0, cpu_gnt, dma_gnt}, 32'd1);
    shadow[8'h83] = 8'hD3;
    tick();
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // ---- Burst cap with handover and no idle gap ----
    do_reset();
    t3_exp = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    t3_caddr = 8'h40; t3_daddr = 8'hC0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = t3_caddr; cpu_wdata = 8'($urandom);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = t3_daddr; dma_wdata = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("t3_beat%0d", i), {30'd0, cpu_gnt, dma_gnt}, {30'd0, t3_exp[i]});
      if (cpu_gnt) shadow[cpu_addr] = cpu_wdata;
      if (dma_gnt) shadow[dma_addr] = dma_wdata;
      tick();
      if (cpu_gnt) begin
        t3_caddr = t3_caddr + 8'd1; cpu_addr = t3_caddr; cpu_wdata = 8'($urandom);
      end
      if (dma_gnt) begin
        t3_daddr = t3_daddr + 8'd1; dma_addr = t3_daddr; dma_wdata = 8'($urandom);
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // ---- DMA burst ending on dma_last at 0xFF, CPU waiting ----
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'hFE; dma_wdata = 8'hA1; dma_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_dma_beat0", {30'd0, cpu_gnt, dma_gnt}, 32'd1);
    shadow[8'hFE] = 8'hA1;
    tick();
    dma_addr = 8'hFF; dma_wdata = 8'hA2; dma_last = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    @(negedge clk);
    check("t4_dma_last_beat", {30'd0, cpu_gnt, dma_gnt}, 32'd1);
    shadow[8'hFF] = 8'hA2;
    tick();
    dma_req = 1'b0; dma_last = 1'b0;
    @(negedge clk);
    check("t4_cpu_after_last", {30'd0, cpu_gnt, dma_gnt}, 32'd2);
    mon_e.data = shadow[8'h05]; mon_e.cyc = cyc;
    cpu_exp.push_back(mon_e);
    tick();
    cpu_req = 1'b0;
    tick();
    check("t4_ram_fe_ff", {16'd0, mem[8'hFE], mem[8'hFF]}, {16'd0, 8'hA1, 8'hA2});

    // ---- Reset asserted in the middle of a DMA write ----
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h20; dma_wdata = 8'h33;
    @(negedge clk);
    @(negedge clk);
    check("t5_write_active", {30'd0, dma_gnt, ram_save}, 32'd3);
    #2 rst = 1'b0;
    #1 check("t5_save_drops", {30'd0, dma_gnt, ram_save}, 32'd0);
    tick();
    rst = 1'b1;
    check("t5_idle_after_reset", {29'd0, dma_gnt, cpu_rvalid, dma_rvalid}, 32'd0);
    dma_req = 1'b0;
    tick();
    check("t5_ram_unchanged", {24'd0, mem[8'h20]}, 32'd0);

    // ---- Randomized concurrent traffic, disjoint address halves ----
    do_reset();
    fork
      for (int n = 0; n < 150; n++) begin
        repeat ($urandom_range(0, 2)) tick();
        cpu_op(1'($urandom), 8'($urandom_range(0, 127)), 8'($urandom));
      end
      for (int n = 0; n < 150; n++) begin
        repeat ($urandom_range(0, 2)) tick();
        dma_op(1'($urandom), 8'($urandom_range(128, 255)), 8'($urandom),
               1'($urandom_range(0, 3) == 0));
      end
    join
    repeat (3) tick();
    check("cpu_reads_drained", cpu_exp.size(), 32'd0);
    check("dma_reads_drained", dma_exp.size(), 32'd0);

`ifdef GRAHZM8_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) cpu_op(1'b1, 8'(8'h60 + i), 8'($urandom));
    for (int i = 0; i < 5; i++) dma_op(1'b1, 8'(8'hE0 + i), 8'($urandom), 1'b0);
    tick();
    check("stat_counts", {stat_cpu_beats, stat_dma_beats}, {16'd3, 16'd5});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h77;
    repeat (70000) tick();
    cpu_req = 1'b0;
    shadow[8'h00] = 8'h77;
    tick();
    check("stat_cpu_saturate", {16'd0, stat_cpu_beats}, 32'h0000FFFF);
`else
    check("stat_tied_zero", {stat_cpu_beats, stat_dma_beats}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_grahzm8_ram_arbiter
`default_nettype wire
